// File: rtl/inv_sbox.sv
// AES inverse S-box: 256-entry byte substitution table.
// Pure combinational lookup, one instance per state byte.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [7:0] TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign y = TBL[a];

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher, one round per clock.
// Includes the combinational key expansion shared with the encrypt side.
module aes_key_expand #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic [32*Nk-1:0]      key,
  output logic [128*(Nr+1)-1:0] fullkeys
);

  localparam int NW = 4*(Nr+1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(
    input logic [31:0] x
  );
    return {SBOX[x[31:24]], SBOX[x[23:16]],
            SBOX[x[15:8]],  SBOX[x[7:0]]};
  endfunction

  always_comb begin : expand
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    t = '0;
    fullkeys = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < Nk) begin
        w[i] = key[32*(Nk-1-i) +: 32];
      end else begin
        t = w[i-1];
        if (i % Nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (Nk > 6 && i % Nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-Nk] ^ t;
      end
    end
    // word 0 lands in the MSBs, so rk[0] is the top 128 bits
    for (int i = 0; i < NW; i++) begin
      fullkeys[32*(NW-1-i) +: 32] = w[i];
    end
  end

endmodule

module aes_decrypt_iter #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [N-1:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int RW = $clog2(Nr+1);
  localparam int KW = 128*(Nr+1);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_t;

  fsm_t          fsm;
  fsm_t          fsm_nxt;
  logic [RW-1:0] rnd;
  logic [N-1:0]  key_q;
  logic [127:0]  data_q;
  logic [KW-1:0] keys_q;
  logic [KW-1:0] keys_in;
  logic [127:0]  rk [Nr+1];
  logic [127:0]  rk_cur;
  logic [127:0]  sr;
  logic [127:0]  sb;
  logic [127:0]  ark;
  logic [127:0]  mc;
  logic [127:0]  nxt;
  logic          unused_keys;

  aes_key_expand #(.Nk(Nk), .Nr(Nr)) u_ks (
    .key      (key_q),
    .fullkeys (keys_q)
  );

  // second schedule gives rk[Nr] in the accept cycle
  aes_key_expand #(.Nk(Nk), .Nr(Nr)) u_ks_in (
    .key      (in_key),
    .fullkeys (keys_in)
  );

  assign unused_keys = ^keys_in[KW-1:128];

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rk[r] = keys_q[128*(Nr-r) +: 128];
  end

  assign rk_cur = rk[rnd];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(
    input logic [7:0] b,
    input logic [3:0] c
  );
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[0] ? b  : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix(
    input logic [31:0] col
  );
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {
      gm(a0,4'he)^gm(a1,4'hb)^gm(a2,4'hd)^gm(a3,4'h9),
      gm(a0,4'h9)^gm(a1,4'he)^gm(a2,4'hb)^gm(a3,4'hd),
      gm(a0,4'hd)^gm(a1,4'h9)^gm(a2,4'he)^gm(a3,4'hb),
      gm(a0,4'hb)^gm(a1,4'hd)^gm(a2,4'h9)^gm(a3,4'he)
    };
  endfunction

  // byte (r,c) sits at index 4c+r counted from the MSB
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(4*c+r) -: 8] =
        data_q[127-8*(4*((c+4-r)%4)+r) -: 8];
      inv_sbox u_isb (
        .a (sr[127-8*(4*c+r) -: 8]),
        .y (sb[127-8*(4*c+r) -: 8])
      );
    end
    assign mc[127-32*c -: 32] = inv_mix(ark[127-32*c -: 32]);
  end

  assign ark = sb ^ rk_cur;
  assign nxt = (rnd == '0) ? ark : mc;

  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE:    if (in_valid)   fsm_nxt = ROUND;
      ROUND:   if (rnd == '0)  fsm_nxt = DONE;
      DONE:    if (out_ready)  fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (fsm == IDLE);
    busy      = (fsm == ROUND);
    out_valid = (fsm == DONE);
    out_data  = data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      rnd    <= '0;
      key_q  <= '0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            key_q  <= in_key;
            data_q <= in_data ^ keys_in[127:0];
            rnd    <= RW'(Nr-1);
          end
        end
        ROUND: begin
          data_q <= nxt;
          if (rnd != '0) rnd <= rnd - RW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboarded bench for aes_decrypt_iter against a behavioural AES model.
// Stimulus pushes expected plaintexts; a monitor pops them on each output.
module tb_aes_decrypt_iter;

  parameter int NK = 4;
  localparam int N  = 32*NK;
  localparam int NR = NK+6;
  localparam int NW = 4*(NR+1);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [N-1:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sb [256];
  bit           chk_int = 1'b0;

  aes_decrypt_iter #(.N(N), .Nr(NR), .Nk(NK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= a;
      a = xt(a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b,
                                      input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  // S-box from its definition: GF inverse then affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h01;
      repeat (254) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^
              rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt,
                                       input logic [N-1:0] key);
    logic [31:0] w [NW];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) w[i] = key[N-1-32*i -: 32];
      else begin
        tmp = w[i-1];
        if (i % NK == 0) begin
          tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (NK > 6 && i % NK == 4) tmp = subw(tmp);
        w[i] = w[i-NK] ^ tmp;
      end
    end
    for (int k = 0; k < 16; k++)
      s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int rd = 1; rd <= NR; rd++) begin
      for (int k = 0; k < 16; k++)
        t[k] = sb[s[4*((k/4 + k%4) % 4) + k%4]];
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rd < NR) begin
          s[4*c]   = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
          s[4*c+3] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int k = 0; k < 16; k++)
        s[k] ^= w[4*rd + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [N-1:0] rand_key();
    logic [N-1:0] k;
    for (int i = 0; i < NK; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // called at a falling edge; returns one cycle after the accept edge
  task automatic send(input logic [127:0] ct,
                      input logic [N-1:0] k,
                      input logic [127:0] exp,
                      input bit hold);
    int t = 0;
    in_valid = 1'b1;
    in_data  = ct;
    in_key   = k;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0");
    end else begin
      exp_q.push_back(exp);
    end
    @(negedge clk);
    in_data = rand_blk();
    in_key  = rand_key();
    if (!hold) in_valid = 1'b0;
  endtask

  // monitor: sees the inputs the next rising edge will sample
  bit pv = 1'b0;
  bit have_prev = 1'b0;
  int acc_cyc = 0;
  int prev_acc = 0;
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (in_valid && in_ready) begin
        if (chk_int && have_prev)
          check("accept_interval", 128'(cyc + 1 - prev_acc),
                128'(NR + 2));
        prev_acc  = cyc + 1;
        have_prev = 1'b1;
        acc_cyc   = cyc + 1;
      end
      if (out_valid && !pv)
        check("latency", 128'(cyc - acc_cyc), 128'(NR));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h expected none",
                   out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
    pv = out_valid;
    if (!chk_int) have_prev = 1'b0;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]   key;
    logic [127:0]   ct;
    logic [127:0]   pt;
    int             lo;
    int             bz;
    int             t;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_data = '0;
    in_key = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_data", out_data, 128'h0);

    // known-answer vector with key 00 01 02 ...
    for (int i = 0; i < N/8; i++) key[N-1-8*i -: 8] = 8'(i);
    case (NK)
      4:       ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      6:       ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: ct = 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
    send(ct, key, 128'h00112233445566778899aabbccddeeff, 1'b0);
    lo = 0;
    bz = 0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) break;
      lo++;
      if (busy) bz++;
      @(negedge clk);
    end
    check("in_ready_low_cycles", 128'(lo), 128'(NR + 1));
    check("busy_cycles", 128'(bz), 128'(NR));

    // output stall with randomized inputs after accept
    key = '0;
    key[N-1 -: 128] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    pt = 128'h3243f6a8885a308d313198a2e0370734;
    out_ready = 1'b0;
    send(enc(pt, key), key, pt, 1'b0);
    t = 0;
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("stall_reached_done", 128'(out_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 128'(out_valid), 128'(1));
      check("stall_data", out_data, pt);
      in_valid = 1'b1;
      in_data = rand_blk();
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready), 128'(1));
    check("idle_out_valid", 128'(out_valid), 128'(0));

    // abort mid-job
    key = rand_key();
    pt = rand_blk();
    send(enc(pt, key), key, pt, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_out_data", out_data, 128'h0);
    key = rand_key();
    pt = rand_blk();
    send(enc(pt, key), key, pt, 1'b0);
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("after_abort_drained", 128'(exp_q.size()), 128'(0));

    // back-to-back with in_valid held high
    @(negedge clk);
    chk_int = 1'b1;
    for (int j = 0; j < 1000; j++) begin
      key = rand_key();
      pt = rand_blk();
      send(enc(pt, key), key, pt, 1'b1);
    end
    in_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk_int = 1'b0;
    check("b2b_drained", 128'(exp_q.size()), 128'(0));
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
